dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Two-requester arbiter that shares the single-port data memory between the processor and the game/display peripheral, e.g. the board-state reader feeding the screen. It sits between the processor's dmem port and the dmem syncram. The processor has priority, and a bounded starvation counter guarantees the peripheral forward progress. Read data returns one cycle after grant, matching the syncram's registered-output latency.

## Interface
- ADDR_W, 12, dmem word-address width
- DATA_W, 32, dmem data width
- STARVE_LIMIT, 4, max consecutive processor wins while peripheral waits; 0 = peripheral always wins ties
- clock  in  1  dmem-domain clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately
- cpu_req  in  1  processor requests dmem this cycle
- cpu_wren  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  processor address
- cpu_data  in  DATA_W  processor store data
- cpu_stall  out  1  cpu_req present but not granted this cycle
- cpu_q  out  DATA_W  load data; equals mem_q
- cpu_valid  out  1  cpu_q holds data for the load granted last cycle
- per_req  in  1  peripheral request
- per_wren  in  1  peripheral write enable
- per_addr  in  ADDR_W  peripheral address
- per_data  in  DATA_W  peripheral write data
- per_gnt  out  1  peripheral granted this cycle (combinational)
- per_q  out  DATA_W  read data; equals mem_q
- per_valid  out  1  per_q holds data for the read granted last cycle
- mem_address  out  ADDR_W  to dmem address
- mem_data  out  DATA_W  to dmem data
- mem_wren  out  1  to dmem wren
- mem_q  in  DATA_W  from dmem q

## Operation
- Grant decision is combinational each cycle from requests and the registered counter `starve_cnt`.
  - per wins if per_req && (!cpu_req || starve_cnt == STARVE_LIMIT).
  - Otherwise cpu wins if cpu_req.
  - Otherwise no grant.
- Memory mux:
  - winner's addr/data/wren drive mem_*.
  - No grant: mem_address = cpu_addr, mem_data = cpu_data, mem_wren = 0.
- cpu_stall = cpu_req && per wins. per_gnt = per wins.
- The loser's write never reaches memory. The loser must hold req/addr/data/wren stable until granted.
- Peripheral handshake:
  - A request is consumed in the cycle per_gnt = 1.
  - The next request may be presented the following cycle; back-to-back grants are allowed.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments, saturating at STARVE_LIMIT, when per_req && cpu wins.
  - Clears when per wins or when per_req = 0.
- Read return tags (registered):
  - cpu_valid <= cpu wins && !cpu_wren.
  - per_valid <= per wins && !per_wren.
  - Writes never produce a valid.

## Timing
- Reset (reset = 0):
  - starve_cnt = 0, cpu_valid = 0, per_valid = 0.
  - mem_wren forced 0, per_gnt forced 0, cpu_stall forced 0, regardless of requests.
- Reset mid-operation: an outstanding read tag is dropped, and no valid is asserted after release.
- First grant is possible in the cycle reset deasserts (reset = 1).
- Read latency:
  - Grant in cycle N, mem_q valid in cycle N+1.
  - The matching *_valid is high only in N+1.
  - cpu_q and per_q are unregistered passthroughs of mem_q.
- Write latency: committed by dmem at the edge ending the grant cycle.
- Starvation bound: per_req held continuously is granted within STARVE_LIMIT+1 cycles.
- Tie at saturation: per wins, cpu_stall = 1, starve_cnt clears, and cpu wins the next tie.
- Both idle: no valids next cycle, starve_cnt clears.

## Test plan
- Reset sequencing:
  - Stimulus: hold reset = 0 with cpu_req = 1, cpu_wren = 1, per_req = 1.
  - Required: mem_wren = 0, per_gnt = 0, cpu_stall = 0, both valids 0.
  - Then release reset: cpu wins, mem_wren = 1.
- CPU-only load/store:
  - Stimulus: store 0xDEADBEEF to addr 0x010, then load addr 0x010.
  - Required: cpu_stall = 0 throughout; cpu_valid = 1 the cycle after the load, with cpu_q = 0xDEADBEEF.
- Contention at STARVE_LIMIT = 4:
  - Stimulus: cpu_req and per_req (read, addr 0x3FF) held high together.
  - Required: cpu wins cycles 0–3; cycle 4 per_gnt = 1, cpu_stall = 1; cycle 5 per_valid = 1 and cpu wins again.
- Write collision:
  - Stimulus: cpu writes 0x1 and per writes 0x2, both to addr 0x020, same cycle, starve_cnt = 0.
  - Required: only 0x1 is written.
  - Then after per's retry, a later read of 0x020 returns 0x2.
- Peripheral-only burst:
  - Stimulus: per reads addrs 0x000–0x007 back-to-back.
  - Required: per_gnt held 1 for 8 cycles; per_valid high for 8 cycles delayed by 1, with data in address order.
- Reset mid-read:
  - Stimulus: per read granted in cycle N, reset = 0 asserted within cycle N.
  - Required: per_valid = 0 in N+1 and after release.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the shared single-port data memory.
// The processor has priority. A saturating starvation counter guarantees
// that the peripheral is granted after a bounded number of processor wins.
// Read data is a passthrough of the syncram's registered output.
// The *_valid outputs tag which requester owns that data.
module dmem_port_arbiter #(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   // processor port
   input  logic              cpu_req_i,
   input  logic              cpu_wren_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_data_i,
   output logic              cpu_stall_o,
   output logic [DATA_W-1:0] cpu_q_o,
   output logic              cpu_valid_o,
   // peripheral port
   input  logic              per_req_i,
   input  logic              per_wren_i,
   input  logic [ADDR_W-1:0] per_addr_i,
   input  logic [DATA_W-1:0] per_data_i,
   output logic              per_gnt_o,
   output logic [DATA_W-1:0] per_q_o,
   output logic              per_valid_o,
   // memory port
   output logic [ADDR_W-1:0] mem_address_o,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_wren_o,
   input  logic [DATA_W-1:0] mem_q_i
);

   // A limit of 0 still needs a one-bit counter to keep widths legal.
   localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
   logic            cpu_valid_q, cpu_valid_d;
   logic            per_valid_q, per_valid_d;
   logic            per_win, cpu_win;

   // Grant decision. Reset masks every grant so nothing reaches memory.
   always_comb begin
      per_win = 1'b0;
      cpu_win = 1'b0;
      if (rst_ni) begin
         per_win = per_req_i && (!cpu_req_i || (starve_cnt_q == CntMax));
         cpu_win = cpu_req_i && !per_win;
      end
   end

   // Memory mux. When nothing is granted, the idle default parks on the processor with writes off.
   always_comb begin
      mem_address_o = cpu_addr_i;
      mem_data_o    = cpu_data_i;
      mem_wren_o    = 1'b0;
      if (per_win) begin
         mem_address_o = per_addr_i;
         mem_data_o    = per_data_i;
         mem_wren_o    = per_wren_i;
      end else if (cpu_win) begin
         mem_wren_o = cpu_wren_i;
      end
   end

   // Next-state: the counter counts only processor wins against a waiting peripheral.
   always_comb begin
      starve_cnt_d = '0;
      if (per_req_i && cpu_win) begin
         starve_cnt_d = (starve_cnt_q == CntMax) ? starve_cnt_q : starve_cnt_q + 1'b1;
      end
      cpu_valid_d = cpu_win && !cpu_wren_i;
      per_valid_d = per_win && !per_wren_i;
   end

   // State registers. Asserting reset drops any outstanding read tag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         starve_cnt_q <= '0;
         cpu_valid_q  <= 1'b0;
         per_valid_q  <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         cpu_valid_q  <= cpu_valid_d;
         per_valid_q  <= per_valid_d;
      end
   end

   assign cpu_stall_o = cpu_req_i && per_win;
   assign per_gnt_o   = per_win;
   assign cpu_valid_o = cpu_valid_q;
   assign per_valid_o = per_valid_q;
   assign cpu_q_o     = mem_q_i;
   assign per_q_o     = mem_q_i;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter.
// A behavioural syncram sits on the memory port.
// A reference model predicts the grants, the memory contents and the read returns.
module tb_dmem_port_arbiter;

   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cpu_req = 1'b0, cpu_wren = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_data = '0;
   logic          per_req = 1'b0, per_wren = 1'b0;
   logic [AW-1:0] per_addr = '0;
   logic [DW-1:0] per_data = '0;
   logic          cpu_stall, cpu_valid, per_gnt, per_valid, mem_wren;
   logic [DW-1:0] cpu_q, per_q, mem_data, mem_q;
   logic [AW-1:0] mem_address;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cpu_req_i    (cpu_req),
      .cpu_wren_i   (cpu_wren),
      .cpu_addr_i   (cpu_addr),
      .cpu_data_i   (cpu_data),
      .cpu_stall_o  (cpu_stall),
      .cpu_q_o      (cpu_q),
      .cpu_valid_o  (cpu_valid),
      .per_req_i    (per_req),
      .per_wren_i   (per_wren),
      .per_addr_i   (per_addr),
      .per_data_i   (per_data),
      .per_gnt_o    (per_gnt),
      .per_q_o      (per_q),
      .per_valid_o  (per_valid),
      .mem_address_o(mem_address),
      .mem_data_o   (mem_data),
      .mem_wren_o   (mem_wren),
      .mem_q_i      (mem_q)
   );

   always #5 clk = ~clk;

   // Syncram with a registered output and read-old-data behaviour.
   logic          clr = 1'b1;
   logic [DW-1:0] dmem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < (1 << AW); i++) dmem[i] <= '0;
         mem_q <= '0;
      end else begin
         if (mem_wren) dmem[mem_address] <= mem_data;
         mem_q <= dmem[mem_address];
      end
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int            wait_cnt = 0;   // consecutive cycles the peripheral has lost
   logic          exp_cv = 1'b0, exp_pv = 1'b0;
   logic [DW-1:0] exp_q = '0;
   logic          pw = 1'b0, cw = 1'b0;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Check outputs for the current cycle, then advance the model over the coming edge.
   task automatic eval();
      logic exp_wren;
      #1;
      chk("cpu_valid", {63'd0, cpu_valid}, {63'd0, exp_cv});
      chk("per_valid", {63'd0, per_valid}, {63'd0, exp_pv});
      if (exp_cv) chk("cpu_q", {32'd0, cpu_q}, {32'd0, exp_q});
      if (exp_pv) chk("per_q", {32'd0, per_q}, {32'd0, exp_q});
      pw = rst_n && per_req && (!cpu_req || wait_cnt >= LIM);
      cw = rst_n && cpu_req && !pw;
      exp_wren = pw ? per_wren : (cw ? cpu_wren : 1'b0);
      chk("per_gnt", {63'd0, per_gnt}, {63'd0, pw});
      chk("cpu_stall", {63'd0, cpu_stall}, {63'd0, cpu_req && pw});
      chk("mem_wren", {63'd0, mem_wren}, {63'd0, exp_wren});
      if (pw) chk("mem_addr", {52'd0, mem_address}, {52'd0, per_addr});
      else if (cw) chk("mem_addr", {52'd0, mem_address}, {52'd0, cpu_addr});
      exp_cv = cw && !cpu_wren;
      exp_pv = pw && !per_wren;
      exp_q  = pw ? ref_mem[per_addr] : ref_mem[cpu_addr];
      if (pw && per_wren) ref_mem[per_addr] = per_data;
      else if (cw && cpu_wren) ref_mem[cpu_addr] = cpu_data;
      wait_cnt = (!rst_n || !per_req || pw) ? 0 : wait_cnt + 1;
   endtask

   task automatic adv();
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
      @(posedge clk);
      #2;
      clr = 1'b0;

      // Reset holds every output quiet despite requests.
      cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h005; cpu_data = 32'h55;
      per_req = 1; per_wren = 0; per_addr = 12'h006;
      for (int i = 0; i < 2; i++) begin
         eval();
         chk("rst_mem_wren", {63'd0, mem_wren}, 64'd0);
         adv();
      end
      // First grant in the cycle reset releases: the processor wins the tie.
      rst_n = 1;
      eval();
      chk("rel_cpu_wins", {63'd0, mem_wren}, 64'd1);
      adv();
      per_req = 0; cpu_req = 0;
      eval(); adv();

      // Processor-only store then load.
      cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h010; cpu_data = 32'hDEADBEEF;
      eval(); chk("st_stall", {63'd0, cpu_stall}, 64'd0); adv();
      cpu_wren = 0;
      eval(); chk("ld_stall", {63'd0, cpu_stall}, 64'd0); adv();
      cpu_req = 0;
      chk("ld_valid", {63'd0, cpu_valid}, 64'd1);
      chk("ld_data", {32'd0, cpu_q}, 64'hDEADBEEF);
      eval(); adv();

      // Sustained contention: four processor wins, then the peripheral wins once.
      cpu_req = 1; cpu_wren = 0; cpu_addr = 12'h010;
      per_req = 1; per_wren = 0; per_addr = 12'h3FF;
      for (int i = 0; i < 6; i++) begin
         eval();
         chk("cont_per_gnt", {63'd0, per_gnt}, {63'd0, i == 4});
         chk("cont_stall", {63'd0, cpu_stall}, {63'd0, i == 4});
         if (i == 5) chk("cont_per_valid", {63'd0, per_valid}, 64'd1);
         adv();
      end
      cpu_req = 0; per_req = 0;
      eval(); adv();

      // Write collision: only the processor's value lands; the peripheral retries.
      cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h020; cpu_data = 32'h1;
      per_req = 1; per_wren = 1; per_addr = 12'h020; per_data = 32'h2;
      eval(); adv();
      chk("coll_only_cpu", {32'd0, dmem[12'h020]}, 64'h1);
      cpu_req = 0;
      eval(); chk("coll_retry_gnt", {63'd0, per_gnt}, 64'd1); adv();
      per_req = 0; per_wren = 0;
      cpu_req = 1; cpu_wren = 0;
      eval(); adv();
      cpu_req = 0;
      chk("coll_read", {32'd0, cpu_q}, 64'h2);
      eval(); adv();

      // Seed words 0..7, then stream them out to the peripheral back-to-back.
      cpu_req = 1; cpu_wren = 1;
      for (int i = 0; i < 8; i++) begin
         cpu_addr = AW'(i); cpu_data = 32'h100 + i;
         eval(); adv();
      end
      cpu_req = 0; cpu_wren = 0;
      per_req = 1; per_wren = 0;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) per_req = 0;
         per_addr = AW'(i);
         eval();
         chk("burst_gnt", {63'd0, per_gnt}, {63'd0, i < 8});
         chk("burst_valid", {63'd0, per_valid}, {63'd0, i > 0});
         if (i > 0) chk("burst_data", {32'd0, per_q}, 64'h100 + 64'(i - 1));
         adv();
      end

      // Reset lands during a granted peripheral read; the tag must vanish.
      per_req = 1; per_wren = 0; per_addr = 12'h003;
      eval();
      chk("mid_gnt", {63'd0, per_gnt}, 64'd1);
      rst_n = 0;
      #1;
      exp_pv = 0; exp_cv = 0; wait_cnt = 0;
      chk("mid_gnt_forced", {63'd0, per_gnt}, 64'd0);
      adv();
      chk("mid_valid_drop", {63'd0, per_valid}, 64'd0);
      per_req = 0;
      eval(); adv();
      rst_n = 1;
      eval(); chk("mid_after_rel", {63'd0, per_valid}, 64'd0); adv();
      eval(); adv();

      // Random traffic; a loser holds its request until it is granted.
      cpu_req = 0; per_req = 0;
      for (int n = 0; n < 400; n++) begin
         if (!cpu_req || cw) begin
            cpu_req  = ($urandom_range(0, 3) != 0);
            cpu_wren = $urandom_range(0, 1) == 1;
            cpu_addr = AW'($urandom_range(0, 15));
            cpu_data = $urandom;
         end
         if (!per_req || pw) begin
            per_req  = ($urandom_range(0, 2) != 0);
            per_wren = $urandom_range(0, 3) == 0;
            per_addr = AW'($urandom_range(0, 15));
            per_data = $urandom;
         end
         eval(); adv();
      end
      cpu_req = 0; per_req = 0;
      eval(); adv();
      eval(); adv();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
